// File: rtl/uart_frame_pkg.sv
// -----------------------------------------------------------------------------
// uart_frame_pkg
// Shared types and defaults for the UART frame parser.
//   state_e    : parser FSM states (HUNT is the idle/reset state, encoded 0)
//   err_code_e : abort reason reported on err_code
//   SYNC_BYTE_DEF / MAX_LEN_DEF : default frame marker and payload capacity
//   ptr_width  : width of len / wr_ptr / rd_ptr for a given capacity
// -----------------------------------------------------------------------------
package uart_frame_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         MAX_LEN_DEF   = 16;

    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        LEN     = 3'd1,
        PAYLOAD = 3'd2,
        CHECK   = 3'd3,
        DRAIN   = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_CHK     = 3'd1,
        ERR_LEN     = 3'd2,
        ERR_UART    = 3'd3,
        ERR_OVERRUN = 3'd4,
        ERR_TIMEOUT = 3'd5
    } err_code_e;

    // Pointers must be able to hold the value max_len itself (the read
    // pointer steps one past the last beat on the final transfer).
    function automatic int ptr_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/uart_frame_buffer.sv
// -----------------------------------------------------------------------------
// uart_frame_buffer
// Payload store for one frame: DEPTH x 8 register array.
// Ports:
//   clk      in   clock
//   wr_en    in   write strobe (synchronous write)
//   wr_addr  in   write index
//   wr_data  in   write byte
//   rd_addr  in   read index (combinational read)
//   rd_data  out  byte at rd_addr
// The array is not reset: contents are only ever read after being written
// by the frame currently being drained.
// -----------------------------------------------------------------------------
module uart_frame_buffer
    import uart_frame_pkg::*;
#(
    parameter int DEPTH = MAX_LEN_DEF,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_frame_parser.sv
// -----------------------------------------------------------------------------
// uart_frame_parser
// Parses SYNC, LEN, LEN payload bytes, CHK (CHK = XOR of LEN and payload)
// from a UART receiver byte stream, buffers the payload and releases it on a
// valid/ready stream only once the checksum has passed.
//
// Optional feature: define UART_FRAME_TIMEOUT_EN to build an inter-byte
// timeout (TIMEOUT_CYCLES) that aborts a stalled frame with code 5. Without
// the macro no counter exists and the parser waits indefinitely.
//
// Ports:
//   clk            in   clock
//   rst            in   synchronous active-high reset
//   rx_data_valid  in   one-cycle byte strobe from the receiver
//   rx_data[7:0]   in   received byte
//   rx_error       in   stop-bit error, qualified by rx_data_valid
//   m_data[7:0]    out  payload byte (0 while m_valid is low)
//   m_valid        out  payload byte available
//   m_ready        in   consumer accepts the byte
//   m_last         out  last payload byte of the frame, qualified by m_valid
//   frame_ok       out  one-cycle pulse: frame passed its checksum
//   frame_err      out  one-cycle pulse: frame aborted
//   err_code[2:0]  out  reason of the last abort, held until the next one
//   busy           out  high in every state except HUNT
//   dbg_state      out  current FSM state
//
// Output handshake: a beat transfers on a rising clk edge where m_valid and
// m_ready are both high. Once m_valid is high it stays high, with m_data and
// m_last stable, until that beat transfers; m_valid never depends on m_ready.
// -----------------------------------------------------------------------------
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int         MAX_LEN        = MAX_LEN_DEF,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_data_valid,
    input  logic [7:0] rx_data,
    input  logic       rx_error,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_last,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [2:0] err_code,
    output logic       busy,
    output state_e     dbg_state
);

    localparam int LW = ptr_width(MAX_LEN);
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    // LEN arrives in one byte, so capacity beyond 255 is unreachable.
    if (MAX_LEN < 1 || MAX_LEN > 255) begin : g_bad_max_len
        $error("uart_frame_parser: MAX_LEN must be in 1..255");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("uart_frame_parser: TIMEOUT_CYCLES must be at least 2");
    end

    state_e    state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LW-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]    chk_q, chk_d;
    logic          frame_ok_q, frame_ok_d;
    logic          frame_err_q, frame_err_d;
    err_code_e     err_code_q, err_code_d;

    logic          wr_en;
    logic [7:0]    rd_data;
    logic          last_beat;

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] to_cnt_q, to_cnt_d;
`endif

    uart_frame_buffer #(
        .DEPTH (MAX_LEN),
        .AW    (IW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q[IW-1:0]),
        .wr_data (rx_data),
        .rd_addr (rd_ptr_q[IW-1:0]),
        .rd_data (rd_data)
    );

    assign last_beat = (rd_ptr_q == len_q - LW'(1));

    assign m_valid   = (state_q == DRAIN);
    assign m_data    = m_valid ? rd_data : 8'h00;
    assign m_last    = m_valid && last_beat;
    assign busy      = (state_q != HUNT);
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        chk_d       = chk_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;
        wr_en       = 1'b0;

        case (state_q)
            HUNT: begin
                // Anything but a clean SYNC is dropped without comment.
                if (rx_data_valid && !rx_error && rx_data == SYNC_BYTE) begin
                    state_d = LEN;
                end
            end

            LEN: begin
                if (rx_data_valid) begin
                    if (rx_error) begin
                        state_d     = HUNT;
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_UART;
                    end else if (rx_data == 8'h00 || 32'(rx_data) > MAX_LEN) begin
                        state_d     = HUNT;
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_LEN;
                    end else begin
                        len_d    = LW'(rx_data);
                        chk_d    = rx_data;
                        wr_ptr_d = '0;
                        state_d  = PAYLOAD;
                    end
                end
            end

            PAYLOAD: begin
                if (rx_data_valid) begin
                    if (rx_error) begin
                        state_d     = HUNT;
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_UART;
                    end else begin
                        wr_en    = 1'b1;
                        chk_d    = chk_q ^ rx_data;
                        wr_ptr_d = wr_ptr_q + LW'(1);
                        if (wr_ptr_q == len_q - LW'(1)) begin
                            state_d = CHECK;
                        end
                    end
                end
            end

            CHECK: begin
                if (rx_data_valid) begin
                    if (rx_error) begin
                        state_d     = HUNT;
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_UART;
                    end else if (rx_data == chk_q) begin
                        state_d    = DRAIN;
                        frame_ok_d = 1'b1;
                        rd_ptr_d   = '0;
                    end else begin
                        state_d     = HUNT;
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CHK;
                    end
                end
            end

            DRAIN: begin
                // The buffer is read-only here: an incoming byte cannot be
                // stored, so it is reported and the drain carries on.
                if (rx_data_valid) begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_OVERRUN;
                end
                if (m_ready) begin
                    rd_ptr_d = rd_ptr_q + LW'(1);
                    if (last_beat) begin
                        state_d = HUNT;
                    end
                end
            end

            default: begin
                state_d = HUNT;
            end
        endcase

`ifdef UART_FRAME_TIMEOUT_EN
        // A byte arriving on the expiry cycle wins: the counter only fires
        // when there is no byte event to process.
        to_cnt_d = to_cnt_q + TW'(1);
        if (rx_data_valid || state_q == HUNT || state_q == DRAIN) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            to_cnt_d    = '0;
            state_d     = HUNT;
            frame_err_d = 1'b1;
            err_code_d  = ERR_TIMEOUT;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            len_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            chk_q       <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            chk_q       <= chk_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
        end
    end

`ifdef UART_FRAME_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_frame_parser.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_parser
// Self-checking bench for uart_frame_parser. Inputs change 1 time unit after
// the rising edge; outputs are recorded by a monitor on the falling edge.
// Build with UART_FRAME_TIMEOUT_EN defined to include the timeout scenario.
// -----------------------------------------------------------------------------
module tb_uart_frame_parser;
    import uart_frame_pkg::*;

    localparam int         MAX_LEN = 16;
    localparam logic [7:0] SYNC    = 8'hA5;
`ifdef UART_FRAME_TIMEOUT_EN
    localparam int         TO      = 50;
`else
    localparam int         TO      = 100000;
`endif

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_data_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_error = 1'b0;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;
    logic       frame_ok;
    logic       frame_err;
    logic [2:0] err_code;
    logic       busy;
    state_e     dbg_state;

    always #5 clk = ~clk;

    uart_frame_parser #(
        .MAX_LEN        (MAX_LEN),
        .SYNC_BYTE      (SYNC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data_valid (rx_data_valid),
        .rx_data       (rx_data),
        .rx_error      (rx_error),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_last        (m_last),
        .frame_ok      (frame_ok),
        .frame_err     (frame_err),
        .err_code      (err_code),
        .busy          (busy),
        .dbg_state     (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    bit         exp_last_q[$];
    logic [2:0] exp_err_q[$];
    int         exp_ok;
    logic [7:0] got_q[$];
    bit         got_last_q[$];
    logic [2:0] got_err_q[$];
    int         ok_cnt;

    // byte list for the frame-level reference model
    logic [7:0] tx_b[$];
    bit         tx_e[$];

    bit rand_ready  = 1'b0;
    bit ready_fixed = 1'b1;

    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);
            else            m_ready = ready_fixed;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid && m_ready) begin
                got_q.push_back(m_data);
                got_last_q.push_back(m_last);
            end
            if (frame_ok)  ok_cnt++;
            if (frame_err) got_err_q.push_back(err_code);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input bit e);
        rx_data_valid = 1'b1;
        rx_data       = d;
        rx_error      = e;
        @(posedge clk);
        #1;
        rx_data_valid = 1'b0;
        rx_error      = 1'b0;
        rx_data       = 8'($urandom_range(0, 255));
    endtask

    task automatic send_tx(input bit gaps);
        for (int i = 0; i < tx_b.size(); i++) begin
            send_byte(tx_b[i], tx_e[i]);
            if (gaps) idle($urandom_range(0, 2));
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || m_valid) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (busy || m_valid) begin
            $display("FAIL wait_idle: busy=%0b m_valid=%0b, required both 0 within 2000 cycles", busy, m_valid);
            errors++;
        end
    endtask

    task automatic clear_sb();
        exp_q.delete(); exp_last_q.delete(); exp_err_q.delete(); exp_ok = 0;
        got_q.delete(); got_last_q.delete(); got_err_q.delete(); ok_cnt = 0;
    endtask

    // Frame-level reference: scan the byte list, find SYNC, validate length,
    // XOR the whole frame and decide its fate.
    task automatic model_tx();
        int i = 0;
        int n = tx_b.size();
        int len;
        logic [7:0] x;
        logic [7:0] pl[$];
        bit abort;
        while (i < n) begin
            if (tx_e[i] || tx_b[i] != SYNC) begin
                i++;
                continue;
            end
            i++;
            if (i >= n) break;
            if (tx_e[i]) begin
                exp_err_q.push_back(3'd3);
                i++;
                continue;
            end
            len = int'(tx_b[i]);
            i++;
            if (len == 0 || len > MAX_LEN) begin
                exp_err_q.push_back(3'd2);
                continue;
            end
            x = 8'(len);
            pl.delete();
            abort = 1'b0;
            for (int k = 0; k < len && !abort; k++) begin
                if (i >= n) begin
                    abort = 1'b1;
                end else if (tx_e[i]) begin
                    exp_err_q.push_back(3'd3);
                    abort = 1'b1;
                    i++;
                end else begin
                    pl.push_back(tx_b[i]);
                    x = x ^ tx_b[i];
                    i++;
                end
            end
            if (abort || i >= n) continue;
            if (tx_e[i]) begin
                exp_err_q.push_back(3'd3);
            end else if (tx_b[i] == x) begin
                exp_ok++;
                for (int k = 0; k < pl.size(); k++) begin
                    exp_q.push_back(pl[k]);
                    exp_last_q.push_back(k == pl.size() - 1);
                end
            end else begin
                exp_err_q.push_back(3'd1);
            end
            i++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        checks++;
        if (m_valid !== 1'b0 || frame_ok !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL reset_strobes: m_valid=%0b frame_ok=%0b frame_err=%0b busy=%0b, required all 0", m_valid, frame_ok, frame_err, busy);
            errors++;
        end
        checks++;
        if (m_data !== 8'h00 || m_last !== 1'b0 || err_code !== 3'd0) begin
            $display("FAIL reset_data: m_data=%h m_last=%0b err_code=%0d, required 00/0/0", m_data, m_last, err_code);
            errors++;
        end
        checks++;
        if (dbg_state !== HUNT) begin
            $display("FAIL reset_state: state=%0d, required HUNT", dbg_state);
            errors++;
        end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_good_frame();
        clear_sb();
        rand_ready  = 1'b0;
        ready_fixed = 1'b1;
        idle(2);
        send_byte(8'hA5, 0); send_byte(8'h03, 0);
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
        send_byte(8'h03, 0);
        checks++;
        if (frame_ok !== 1'b1 || m_valid !== 1'b1 || m_data !== 8'h11) begin
            $display("FAIL good_latency: frame_ok=%0b m_valid=%0b m_data=%h, required 1/1/11", frame_ok, m_valid, m_data);
            errors++;
        end
        wait_idle();
        exp_q = '{8'h11, 8'h22, 8'h33};
        exp_last_q = '{1'b0, 1'b0, 1'b1};
        checks++;
        if (got_q.size() != 3) begin
            $display("FAIL good_beats: got %0d beats, required 3", got_q.size());
            errors++;
        end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i] || got_last_q[i] !== exp_last_q[i]) begin
                $display("FAIL good_beat%0d: data=%h last=%0b, required %h/%0b", i, got_q[i], got_last_q[i], exp_q[i], exp_last_q[i]);
                errors++;
            end
        end
        checks++;
        if (ok_cnt != 1 || got_err_q.size() != 0) begin
            $display("FAIL good_status: ok pulses=%0d err pulses=%0d, required 1/0", ok_cnt, got_err_q.size());
            errors++;
        end
    endtask

    task automatic test_bad_checksum();
        clear_sb();
        send_byte(8'hA5, 0); send_byte(8'h03, 0);
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
        send_byte(8'h04, 0);
        checks++;
        if (frame_err !== 1'b1 || err_code !== 3'd1 || m_valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL bad_chk: frame_err=%0b err_code=%0d m_valid=%0b busy=%0b, required 1/1/0/0", frame_err, err_code, m_valid, busy);
            errors++;
        end
        idle(3);
        checks++;
        if (frame_err !== 1'b0 || err_code !== 3'd1 || got_q.size() != 0 || ok_cnt != 0) begin
            $display("FAIL bad_chk_after: frame_err=%0b err_code=%0d beats=%0d ok=%0d, required 0/1 held/0/0", frame_err, err_code, got_q.size(), ok_cnt);
            errors++;
        end
    endtask

    task automatic test_length_bounds();
        logic [7:0] x;
        clear_sb();
        rand_ready = 1'b1;
        send_byte(8'hA5, 0); send_byte(8'h00, 0);
        checks++;
        if (frame_err !== 1'b1 || err_code !== 3'd2 || busy !== 1'b0) begin
            $display("FAIL len_zero: frame_err=%0b err_code=%0d busy=%0b, required 1/2/0", frame_err, err_code, busy);
            errors++;
        end
        idle(1);
        send_byte(8'hA5, 0); send_byte(8'(MAX_LEN + 1), 0);
        checks++;
        if (frame_err !== 1'b1 || err_code !== 3'd2 || busy !== 1'b0) begin
            $display("FAIL len_over: frame_err=%0b err_code=%0d busy=%0b, required 1/2/0", frame_err, err_code, busy);
            errors++;
        end
        idle(1);
        send_byte(8'hA5, 0); send_byte(8'(MAX_LEN), 0);
        x = 8'(MAX_LEN);
        for (int i = 0; i < MAX_LEN; i++) begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            exp_last_q.push_back(i == MAX_LEN - 1);
            x = x ^ b;
            send_byte(b, 0);
        end
        send_byte(x, 0);
        wait_idle();
        checks++;
        if (got_q.size() != MAX_LEN || ok_cnt != 1) begin
            $display("FAIL len_max: beats=%0d ok=%0d, required %0d/1", got_q.size(), ok_cnt, MAX_LEN);
            errors++;
        end
        for (int i = 0; i < MAX_LEN && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i] || got_last_q[i] !== exp_last_q[i]) begin
                $display("FAIL len_max_beat%0d: data=%h last=%0b, required %h/%0b", i, got_q[i], got_last_q[i], exp_q[i], exp_last_q[i]);
                errors++;
            end
        end
        rand_ready = 1'b0;
    endtask

    task automatic test_hunt_uart_error();
        clear_sb();
        send_byte(8'h00, 0); send_byte(8'hFF, 0);
        checks++;
        if (busy !== 1'b0 || frame_err !== 1'b0) begin
            $display("FAIL hunt_ignore: busy=%0b frame_err=%0b, required 0/0", busy, frame_err);
            errors++;
        end
        send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'hAA, 0);
        send_byte(8'hBB, 1);
        checks++;
        if (frame_err !== 1'b1 || err_code !== 3'd3 || busy !== 1'b0) begin
            $display("FAIL uart_err: frame_err=%0b err_code=%0d busy=%0b, required 1/3/0", frame_err, err_code, busy);
            errors++;
        end
        send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h5C, 0);
        send_byte(8'h01 ^ 8'h5C, 0);
        wait_idle();
        checks++;
        if (got_q.size() != 1 || ok_cnt != 1 || got_err_q.size() != 1) begin
            $display("FAIL uart_recover: beats=%0d ok=%0d errs=%0d, required 1/1/1", got_q.size(), ok_cnt, got_err_q.size());
            errors++;
        end else begin
            checks++;
            if (got_q[0] !== 8'h5C || got_last_q[0] !== 1'b1) begin
                $display("FAIL uart_recover_beat: data=%h last=%0b, required 5c/1", got_q[0], got_last_q[0]);
                errors++;
            end
        end
    endtask

    task automatic test_backpressure_overrun();
        clear_sb();
        rand_ready  = 1'b0;
        ready_fixed = 1'b0;
        idle(2);
        send_byte(8'hA5, 0); send_byte(8'h02, 0);
        send_byte(8'hC3, 0); send_byte(8'h5A, 0);
        send_byte(8'h02 ^ 8'hC3 ^ 8'h5A, 0);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'hC3 || m_last !== 1'b0) begin
            $display("FAIL bp_first: m_valid=%0b m_data=%h m_last=%0b, required 1/c3/0", m_valid, m_data, m_last);
            errors++;
        end
        idle(3);
        send_byte(8'h77, 0);
        checks++;
        if (frame_err !== 1'b1 || err_code !== 3'd4 || dbg_state !== DRAIN) begin
            $display("FAIL overrun: frame_err=%0b err_code=%0d state=%0d, required 1/4/DRAIN", frame_err, err_code, dbg_state);
            errors++;
        end
        idle(6);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'hC3 || m_last !== 1'b0 || got_q.size() != 0) begin
            $display("FAIL bp_hold: m_valid=%0b m_data=%h m_last=%0b beats=%0d, required 1/c3/0/0", m_valid, m_data, m_last, got_q.size());
            errors++;
        end
        ready_fixed = 1'b1;
        wait_idle();
        exp_q = '{8'hC3, 8'h5A};
        exp_last_q = '{1'b0, 1'b1};
        checks++;
        if (got_q.size() != 2 || got_err_q.size() != 1) begin
            $display("FAIL bp_release: beats=%0d errs=%0d, required 2/1", got_q.size(), got_err_q.size());
            errors++;
        end
        for (int i = 0; i < 2 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i] || got_last_q[i] !== exp_last_q[i]) begin
                $display("FAIL bp_beat%0d: data=%h last=%0b, required %h/%0b", i, got_q[i], got_last_q[i], exp_q[i], exp_last_q[i]);
                errors++;
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_sb();
        rand_ready  = 1'b0;
        ready_fixed = 1'b1;
        idle(2);
        // frame, immediately followed (first HUNT cycle) by another frame
        tx_b = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h32};
        tx_e = '{0, 0, 0, 0, 0};
        model_tx();
        send_tx(0);
        wait_idle();
        tx_b = '{8'hA5, 8'h01, 8'hA5, 8'hA4};
        tx_e = '{0, 0, 0, 0};
        model_tx();
        send_tx(0);
        wait_idle();
        // length error straight into a good frame
        tx_b = '{8'hA5, 8'h00, 8'hA5, 8'h01, 8'h7E, 8'h7F};
        tx_e = '{0, 0, 0, 0, 0, 0};
        model_tx();
        send_tx(0);
        wait_idle();
        checks++;
        if (got_q.size() != exp_q.size() || ok_cnt != exp_ok || got_err_q.size() != exp_err_q.size()) begin
            $display("FAIL b2b_counts: beats=%0d/%0d ok=%0d/%0d errs=%0d/%0d (got/required)", got_q.size(), exp_q.size(), ok_cnt, exp_ok, got_err_q.size(), exp_err_q.size());
            errors++;
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i] || got_last_q[i] !== exp_last_q[i]) begin
                $display("FAIL b2b_beat%0d: data=%h last=%0b, required %h/%0b", i, got_q[i], got_last_q[i], exp_q[i], exp_last_q[i]);
                errors++;
            end
        end
    endtask

    task automatic test_random();
        clear_sb();
        rand_ready = 1'b1;
        for (int f = 0; f < 30; f++) begin
            int kind;
            int len;
            int j0;
            logic [7:0] x;
            tx_b.delete();
            tx_e.delete();
            for (int j = $urandom_range(0, 2); j > 0; j--) begin
                logic [7:0] v;
                bit e;
                v = 8'($urandom_range(0, 255));
                e = ($urandom_range(0, 3) == 0);
                if (!e && v == SYNC) v = 8'h00;
                tx_b.push_back(v);
                tx_e.push_back(e);
            end
            j0 = tx_b.size();
            kind = $urandom_range(0, 5);
            len = $urandom_range(1, MAX_LEN);
            tx_b.push_back(SYNC); tx_e.push_back(0);
            if (kind == 4) begin
                tx_b.push_back($urandom_range(0, 1) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
                tx_e.push_back(0);
            end else begin
                tx_b.push_back(8'(len)); tx_e.push_back(0);
                x = 8'(len);
                for (int k = 0; k < len; k++) begin
                    logic [7:0] b;
                    b = 8'($urandom_range(0, 255));
                    x = x ^ b;
                    tx_b.push_back(b); tx_e.push_back(0);
                end
                if (kind == 3) x = x ^ 8'($urandom_range(1, 255));
                tx_b.push_back(x); tx_e.push_back(0);
                if (kind == 5) begin
                    int p;
                    p = j0 + $urandom_range(1, len + 2);
                    tx_e[p] = 1'b1;
                    while (tx_b.size() > p + 1) begin
                        void'(tx_b.pop_back());
                        void'(tx_e.pop_back());
                    end
                end
            end
            model_tx();
            send_tx(1);
            wait_idle();
        end
        rand_ready = 1'b0;
        checks++;
        if (got_q.size() != exp_q.size() || ok_cnt != exp_ok || got_err_q.size() != exp_err_q.size()) begin
            $display("FAIL rand_counts: beats=%0d/%0d ok=%0d/%0d errs=%0d/%0d (got/required)", got_q.size(), exp_q.size(), ok_cnt, exp_ok, got_err_q.size(), exp_err_q.size());
            errors++;
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i] || got_last_q[i] !== exp_last_q[i]) begin
                $display("FAIL rand_beat%0d: data=%h last=%0b, required %h/%0b", i, got_q[i], got_last_q[i], exp_q[i], exp_last_q[i]);
                errors++;
            end
        end
        for (int i = 0; i < exp_err_q.size() && i < got_err_q.size(); i++) begin
            checks++;
            if (got_err_q[i] !== exp_err_q[i]) begin
                $display("FAIL rand_err%0d: err_code=%0d, required %0d", i, got_err_q[i], exp_err_q[i]);
                errors++;
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_sb();
        send_byte(8'hA5, 0); send_byte(8'h03, 0); send_byte(8'h11, 0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(2);
        checks++;
        if (busy !== 1'b0 || frame_err !== 1'b0 || err_code !== 3'd0 || got_err_q.size() != 0) begin
            $display("FAIL reset_mid: busy=%0b frame_err=%0b err_code=%0d errs=%0d, required 0/0/0/0", busy, frame_err, err_code, got_err_q.size());
            errors++;
        end
    endtask

`ifdef UART_FRAME_TIMEOUT_EN
    task automatic test_timeout();
        clear_sb();
        ready_fixed = 1'b1;
        send_byte(8'hA5, 0); send_byte(8'h02, 0);
        idle(TO - 1);
        checks++;
        if (busy !== 1'b1 || frame_err !== 1'b0) begin
            $display("FAIL timeout_early: busy=%0b frame_err=%0b, required 1/0", busy, frame_err);
            errors++;
        end
        idle(1);
        checks++;
        if (frame_err !== 1'b1 || err_code !== 3'd5 || busy !== 1'b0) begin
            $display("FAIL timeout: frame_err=%0b err_code=%0d busy=%0b, required 1/5/0", frame_err, err_code, busy);
            errors++;
        end
        // byte lands on the expiry cycle: it is processed, no timeout
        send_byte(8'hA5, 0); send_byte(8'h02, 0);
        idle(TO - 1);
        send_byte(8'h31, 0);
        checks++;
        if (frame_err !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL timeout_byte_wins: frame_err=%0b busy=%0b, required 0/1", frame_err, busy);
            errors++;
        end
        send_byte(8'h32, 0);
        send_byte(8'h02 ^ 8'h31 ^ 8'h32, 0);
        wait_idle();
        checks++;
        if (ok_cnt != 1 || got_q.size() != 2 || got_err_q.size() != 1) begin
            $display("FAIL timeout_recover: ok=%0d beats=%0d errs=%0d, required 1/2/1", ok_cnt, got_q.size(), got_err_q.size());
            errors++;
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1;
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_length_bounds();
        test_hunt_uart_error();
        test_backpressure_overrun();
        test_back_to_back();
        test_random();
`ifdef UART_FRAME_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
